pwm_decoder: RTL

- Receiver counterpart of the team's N-bit PWM DAC: samples an asynchronous PWM line and recovers the on-time word (t_on) and period of each complete PWM cycle.
- Used for loopback checking of the sound-generator PWM output and for decoding external PWM control inputs.
- A DAC-generated stream with period 2^N and on-time T yields duty = T, period = 2^N.
- Flags constant-low and constant-high inputs via a timeout.

---
 rtl/pwm_decoder_if.sv | 30 +++
 rtl/pwm_decoder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/pwm_decoder_if.sv
// PWM decoder bus: the sampled PWM line plus everything recovered from it.
//   pwm_in     : asynchronous PWM line (driven by the source)
//   duty       : high-time of the last measurement, saturated at 2^N-1
//   period     : rise-to-rise clocks of the last complete cycle, 0 after a stuck report
//   valid      : one-cycle report strobe
//   stuck_low  : last report was a constant-low timeout
//   stuck_high : last report was a constant-high timeout
//   locked     : a qualified rising edge has been seen and a measurement is running
// master = PWM source / result consumer, slave = the decoder.
interface pwm_decoder_if #(
  parameter int unsigned N = 8
);
  logic         pwm_in;
  logic [N-1:0] duty;
  logic [N:0]   period;
  logic         valid;
  logic         stuck_low;
  logic         stuck_high;
  logic         locked;

  modport master (
    output pwm_in,
    input  duty, period, valid, stuck_low, stuck_high, locked
  );

  modport slave (
    input  pwm_in,
    output duty, period, valid, stuck_low, stuck_high, locked
  );
endinterface

// File: rtl/pwm_decoder.sv
// PWM decoder: synchronizes an asynchronous PWM line and measures the high time and the
// rise-to-rise period of every complete cycle. A line that produces no complete cycle for
// TIMEOUT clocks is reported as stuck low or stuck high, repeating every TIMEOUT+1 clocks.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : pwm_decoder_if slave (pwm_in in; duty, period, valid, stuck_low, stuck_high,
//           locked out)
module pwm_decoder #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 2**(N+1)-1
) (
  input logic         clk,
  input logic         reset,
  pwm_decoder_if.slave bus
);

  localparam logic [N:0] TimeoutVal = (N+1)'(TIMEOUT);
  localparam logic [N:0] CntOne     = (N+1)'(1);
  localparam logic [N:0] CntMax     = '1;

  typedef enum logic [1:0] {StAcq, StHigh, StLow} state_e;

  // Input synchronizer and edge detection
  logic [SYNC_STAGES-1:0] sync_q;
  // Tracks which synchronizer stages hold real samples since reset; the cleared flops
  // read as low but are not an observation of the line.
  logic [SYNC_STAGES-1:0] primed_q;
  logic                   s, s_d_q, primed, rise, fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      primed_q <= '0;
      s_d_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
      primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
      s_d_q    <= s;
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign primed = primed_q[SYNC_STAGES-1];
  assign rise   = s & ~s_d_q;
  assign fall   = ~s & s_d_q;

  // Measurement state
  state_e       state_q, state_d;
  logic [N:0]   per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
  logic         seen_low_q, seen_low_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N:0]   period_q, period_d;
  logic         valid_q, valid_d;
  logic         stuck_low_q, stuck_low_d, stuck_high_q, stuck_high_d;

  logic [N:0]   per_inc, hi_inc;
  logic         timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StAcq;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      seen_low_q   <= 1'b0;
      duty_q       <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      seen_low_q   <= seen_low_d;
      duty_q       <= duty_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  // Saturating increments
  assign per_inc = (per_cnt_q == CntMax) ? per_cnt_q : per_cnt_q + CntOne;
  assign hi_inc  = (hi_cnt_q == CntMax) ? hi_cnt_q : hi_cnt_q + CntOne;
  // A rise in the same cycle takes priority over the timeout.
  assign timeout = (per_cnt_q == TimeoutVal) && !rise;

  always_comb begin
    state_d      = state_q;
    per_cnt_d    = per_inc;
    hi_cnt_d     = hi_cnt_q;
    seen_low_d   = seen_low_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stuck_low_d  = stuck_low_q;
    stuck_high_d = stuck_high_q;

    if (timeout) begin
      duty_d       = s ? '1 : '0;
      stuck_low_d  = ~s;
      stuck_high_d = s;
      period_d     = '0;
      valid_d      = 1'b1;
      per_cnt_d    = '0;
      hi_cnt_d     = '0;
      state_d      = StAcq;
      seen_low_d   = ~s;
    end else begin
      unique case (state_q)
        StAcq: begin
          if (primed && !s) seen_low_d = 1'b1;
          // A rise without a preceding low level may be the line sitting high at reset.
          if (rise && seen_low_q) begin
            per_cnt_d = CntOne;
            hi_cnt_d  = CntOne;
            state_d   = StHigh;
          end
        end
        StHigh: begin
          if (s) hi_cnt_d = hi_inc;
          if (fall) state_d = StLow;
        end
        StLow: begin
          if (rise) begin
            // hi_cnt above 2^N-1 has its top bit set; clamp to all-ones.
            duty_d       = hi_cnt_q[N] ? '1 : hi_cnt_q[N-1:0];
            period_d     = per_cnt_q;
            valid_d      = 1'b1;
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            per_cnt_d    = CntOne;
            hi_cnt_d     = CntOne;
            state_d      = StHigh;
          end
        end
        default: state_d = StAcq;
      endcase
    end
  end

  assign bus.duty       = duty_q;
  assign bus.period     = period_q;
  assign bus.valid      = valid_q;
  assign bus.stuck_low  = stuck_low_q;
  assign bus.stuck_high = stuck_high_q;
  assign bus.locked     = (state_q != StAcq);

endmodule
